// File: rtl/alu_issue_queue_pkg.sv
// Shared ALU types plus the issue queue's result-slot state and widths.
package definitions;

  typedef enum logic [1:0] {ADD, SUB, MULT, BAND} opcode_t;
  typedef enum logic {UNSIGNED, SIGNED} op_type_t;
  typedef logic [23:0] operand_t;
  typedef logic [47:0] data_t;

  typedef struct packed {
    opcode_t  opc;
    op_type_t op_type;
    operand_t op_a;
    operand_t op_b;
  } instruction_t;

  typedef enum logic {SLOT_EMPTY, SLOT_FULL} res_slot_t;

  localparam int INSTR_W = $bits(instruction_t);

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/alu_issue_queue_fifo.sv
// Power-of-two synchronous FIFO; pointers wrap naturally, count is 0..DEPTH.
module sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0][WIDTH-1:0] mem_q;
  logic [AW-1:0]               wr_ptr_q, rd_ptr_q;
  logic [AW:0]                 count_q;

  // Storage is not reset: count gates every read, so stale words are never seen.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;
  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);

endmodule

// File: rtl/alu_issue_queue.sv
// Issue stage ahead of the combinational ALU: FIFO head drives instr, the ALU result
// is captured in a one-entry result slot. ALU_ISSUE_STATS_EN adds issued/stall counters.
module alu_issue_queue
  import definitions::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  instruction_t       in_instr,
  output instruction_t       instr,
  input  data_t              alu_out,
  output logic               res_valid,
  input  logic               res_ready,
  output data_t              res_data,
  output opcode_t            res_opc,
  output logic [CNT_W-1:0]   count
`ifdef ALU_ISSUE_STATS_EN
  ,output logic [15:0]       issued_cnt,
  output logic [15:0]        stall_cnt
`endif
);

  logic               push, pop;
  logic               fifo_full, fifo_empty;
  logic [INSTR_W-1:0] fifo_rdata;
  res_slot_t          state_q;
  data_t              res_data_q;
  opcode_t            res_opc_q;

  sync_fifo #(.DEPTH(DEPTH), .WIDTH(INSTR_W)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (in_instr),
    .rdata (fifo_rdata),
    .count (count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // No pass-through when full: in_ready ignores a same-cycle pop.
  assign in_ready  = !fifo_full;
  assign push      = in_valid && in_ready;
  assign pop       = !fifo_empty && (state_q == SLOT_EMPTY || res_ready);
  assign instr     = fifo_empty ? '0 : instruction_t'(fifo_rdata);
  assign res_valid = (state_q == SLOT_FULL);
  assign res_data  = res_data_q;
  assign res_opc   = res_opc_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= SLOT_EMPTY;
      res_data_q <= '0;
      res_opc_q  <= ADD;
    end else begin
      case (state_q)
        SLOT_EMPTY: begin
          if (!fifo_empty) begin
            res_data_q <= alu_out;
            res_opc_q  <= instr.opc;
            state_q    <= SLOT_FULL;
          end
        end
        SLOT_FULL: begin
          if (res_ready) begin
            if (!fifo_empty) begin
              res_data_q <= alu_out;
              res_opc_q  <= instr.opc;
            end else begin
              state_q <= SLOT_EMPTY;
            end
          end
        end
        default: state_q <= SLOT_EMPTY;
      endcase
    end
  end

`ifdef ALU_ISSUE_STATS_EN
  logic [15:0] issued_q, stall_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      issued_q <= '0;
      stall_q  <= '0;
    end else begin
      if (pop)                    issued_q <= sat_inc16(issued_q);
      if (res_valid && !res_ready) stall_q <= sat_inc16(stall_q);
    end
  end

  assign issued_cnt = issued_q;
  assign stall_cnt  = stall_q;
`endif

endmodule

// File: tb/tb_alu_issue_queue.sv
// Randomized and directed checks of alu_issue_queue against a queue-based reference model.
module tb_alu_issue_queue;
  import definitions::*;

  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  instruction_t     in_instr = '0;
  instruction_t     instr;
  data_t            alu_out;
  logic             res_valid;
  logic             res_ready = 1'b0;
  data_t            res_data;
  opcode_t          res_opc;
  logic [CNT_W-1:0] count;
`ifdef ALU_ISSUE_STATS_EN
  logic [15:0]      issued_cnt, stall_cnt;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model: pending instructions plus the result held for the consumer.
  instruction_t q[$];
  bit           m_valid;
  data_t        m_data;
  opcode_t      m_opc;
  int           m_issued, m_stall;

  alu_issue_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .instr(instr), .alu_out(alu_out),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_opc(res_opc), .count(count)
`ifdef ALU_ISSUE_STATS_EN
    ,.issued_cnt(issued_cnt), .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic data_t alu_ref(input instruction_t i);
    data_t a, b;
    a = (i.op_type == SIGNED) ? {{24{i.op_a[23]}}, i.op_a} : {24'd0, i.op_a};
    b = (i.op_type == SIGNED) ? {{24{i.op_b[23]}}, i.op_b} : {24'd0, i.op_b};
    case (i.opc)
      ADD:     return a + b;
      SUB:     return a - b;
      MULT:    return a * b;
      default: return a & b;
    endcase
  endfunction

  always_comb alu_out = alu_ref(instr);

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  function automatic instruction_t mk(input opcode_t o, input op_type_t t,
                                      input logic [23:0] a, input logic [23:0] b);
    instruction_t x;
    x.opc = o; x.op_type = t; x.op_a = a; x.op_b = b;
    return x;
  endfunction

  function automatic instruction_t rnd_instr();
    return mk(opcode_t'($urandom_range(0, 3)), op_type_t'($urandom_range(0, 1)),
              24'($urandom), 24'($urandom));
  endfunction

  // One clock: advance the model from the pre-edge inputs, then compare after the edge.
  task automatic cycle();
    bit push, pop;
    if (rst) begin
      q.delete();
      m_valid = 0; m_data = '0; m_opc = ADD; m_issued = 0; m_stall = 0;
    end else begin
      push = in_valid && (q.size() < DEPTH);
      pop  = (q.size() != 0) && (!m_valid || res_ready);
      if (m_valid && !res_ready && m_stall < 16'hFFFF) m_stall++;
      if (pop) begin
        m_data = alu_ref(q[0]);
        m_opc  = q[0].opc;
        m_valid = 1;
        void'(q.pop_front());
        if (m_issued < 16'hFFFF) m_issued++;
      end else if (res_ready) begin
        m_valid = 0;
      end
      if (push) q.push_back(in_instr);
    end
    @(posedge clk);
    #1;
    chk("count", 64'(count), 64'(q.size()));
    chk("in_ready", 64'(in_ready), 64'(q.size() < DEPTH));
    chk("res_valid", 64'(res_valid), 64'(m_valid));
    chk("res_data", 64'(res_data), 64'(m_data));
    chk("res_opc", 64'(res_opc), 64'(m_opc));
    chk("instr", 64'(instr), (q.size() != 0) ? 64'(q[0]) : 64'd0);
`ifdef ALU_ISSUE_STATS_EN
    chk("issued_cnt", 64'(issued_cnt), 64'(m_issued));
    chk("stall_cnt", 64'(stall_cnt), 64'(m_stall));
`endif
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
  endtask

  initial begin
    int acc;
    #1;
    do_reset();
    chk("rst_res_opc", 64'(res_opc), 64'(ADD));

    // Single ADD: visible on instr after accept, result one edge later.
    res_ready = 1'b1;
    in_valid = 1'b1; in_instr = mk(ADD, UNSIGNED, 24'h5, 24'h3);
    cycle();
    in_valid = 1'b0;
    chk("t1_valid_early", 64'(res_valid), 64'd0);
    cycle();
    chk("t1_valid", 64'(res_valid), 64'd1);
    chk("t1_data", 64'(res_data), 64'd8);
    cycle();

    // Back-to-back SUB then MULT.
    in_valid = 1'b1; in_instr = mk(SUB, UNSIGNED, 24'd5, 24'd3);
    cycle();
    in_instr = mk(MULT, UNSIGNED, 24'd12, 24'd3);
    cycle();
    in_valid = 1'b0;
    chk("t2_sub", 64'(res_data), 64'd2);
    cycle();
    chk("t2_mult", 64'(res_data), 64'd36);
    cycle();

    // Stalled consumer: capacity is DEPTH+1.
    res_ready = 1'b0; acc = 0;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; in_instr = mk(ADD, UNSIGNED, 24'(100 + i), 24'd1);
      if (in_ready) acc++;
      cycle();
    end
    chk("t3_accepts", 64'(acc), 64'd5);
    chk("t3_count", 64'(count), 64'd4);
    chk("t3_in_ready", 64'(in_ready), 64'd0);
    chk("t3_hold", 64'(res_data), 64'd101);

    // Full queue with push and pop in the same cycle: no pass-through.
    in_valid = 1'b1; in_instr = mk(SUB, UNSIGNED, 24'd9, 24'd9);
    res_ready = 1'b1;
    chk("t4_in_ready", 64'(in_ready), 64'd0);
    cycle();
    chk("t4_count", 64'(count), 64'd3);
    chk("t4_next", 64'(res_data), 64'd102);
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) cycle();
    chk("t4_drained", 64'(count), 64'd0);

    // Reset mid-operation with count=3 and a held result.
    res_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_instr = rnd_instr();
      cycle();
    end
    chk("t5_pre_count", 64'(count), 64'd3);
    chk("t5_pre_valid", 64'(res_valid), 64'd1);
    rst = 1'b1; in_valid = 1'b1; res_ready = 1'b1;
    cycle();
    rst = 1'b0; in_valid = 1'b0;
    chk("t5_count", 64'(count), 64'd0);
    chk("t5_valid", 64'(res_valid), 64'd0);
    chk("t5_instr", 64'(instr), 64'd0);
    chk("t5_data", 64'(res_data), 64'd0);
    for (int i = 0; i < 3; i++) cycle();

`ifdef ALU_ISSUE_STATS_EN
    // Three issues with four stalled cycles while a result is held.
    do_reset();
    res_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_instr = rnd_instr();
      cycle();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) cycle();
    res_ready = 1'b1;
    for (int i = 0; i < 3; i++) cycle();
    chk("t6_issued", 64'(issued_cnt), 64'd3);
    chk("t6_stall", 64'(stall_cnt), 64'd4);
`endif

    // Random traffic with occasional resets; exercises pointer wrap.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      rst       = ($urandom_range(0, 199) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      res_ready = ($urandom_range(0, 2) != 0);
      in_instr  = rnd_instr();
      cycle();
    end
    rst = 1'b0; in_valid = 1'b0; res_ready = 1'b1;
    for (int i = 0; i < DEPTH + 2; i++) cycle();
    chk("final_empty", 64'(count), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_issue_queue.md
Name: alu_issue_queue

Overview:
- Issue stage placed directly upstream of the combinational `alu`.
- Buffers incoming `instruction_t` words in a small FIFO and presents the head entry on the ALU's `instr` input.
- Captures the ALU's `alu_out` into a registered result slot and offers it downstream over a valid/ready handshake.
- Decouples the instruction producer from the result consumer so that either side can stall.

Parameters:
- DEPTH, 4, FIFO entries; must be a power of 2 and >= 2.
- CNT_W, $clog2(DEPTH)+1, width of the occupancy count.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  producer has an instruction on in_instr.
- in_ready  out  1  queue can accept; a transfer occurs when in_valid && in_ready at the clock edge.
- in_instr  in  $bits(instruction_t)  instruction, packed {opc, op_type, op_a, op_b}.
- instr  out  $bits(instruction_t)  to ALU `instr`; FIFO head entry.
- alu_out  in  $bits(data_t)  from ALU; combinational function of instr.
- res_valid  out  1  res_data holds an unconsumed result.
- res_ready  in  1  consumer accepts the result.
- res_data  out  $bits(data_t)  registered ALU result.
- res_opc  out  $bits(opcode_t)  opcode that produced res_data.
- count  out  CNT_W  FIFO occupancy, 0..DEPTH; excludes the result slot.

Behaviour:
- Reset (rst=1 at an edge): wr_ptr=rd_ptr=0, count=0, res_valid=0, res_data=0, res_opc=ADD, slot state=EMPTY. Reset has priority over every other event, including mid-transfer.
- Reset mid-operation: in-flight FIFO entries and any held result are discarded. Nothing is emitted after rst.
- in_ready = (count != DEPTH). There is no pass-through when full; a simultaneous pop does not raise in_ready in the same cycle.
- instr = head entry when count != 0, else all zeros. The ALU result for an empty queue is ignored.
- Result slot FSM:
  - EMPTY: if count != 0, load res_data <= alu_out and res_opc <= head opc, pop the head, and go to FULL.
  - FULL: if res_ready && count != 0, reload from the new head and pop, staying FULL (back-to-back, one result per cycle). If res_ready && count == 0, go to EMPTY. If !res_ready, hold res_data and res_opc and do not pop.
- res_valid = (state == FULL).
- pop = count != 0 && (state == EMPTY || res_ready). push = in_valid && in_ready.
- count update: count + push - pop. A simultaneous push and pop leaves count unchanged.
- Pointers are log2(DEPTH) bits wide and wrap naturally modulo DEPTH.
- Latency: an instruction accepted at edge N appears on instr after edge N. If it is the only entry and the slot is free, res_valid rises after edge N+1. Minimum in-to-result latency is 2 cycles.
- Capacity with res_ready=0: DEPTH+1 instructions (DEPTH in the FIFO plus 1 in the result slot).
- Data path width is taken from the package; no arithmetic is performed here.
- Ordering: results leave strictly in acceptance order.

Optional Feature:
- Macro: ALU_ISSUE_STATS_EN.
- Defined: adds outputs issued_cnt[15:0] and stall_cnt[15:0], both cleared by rst.
  - issued_cnt increments on every pop.
  - stall_cnt increments on every cycle with res_valid && !res_ready.
  - Both counters saturate at 16'hFFFF.
- Undefined: these ports and their logic are absent; all other behaviour is identical.

Decomposition:
- Package `definitions`: reuse instruction_t, data_t, opcode_t, and the op_type enum.
- Add to the package: typedef enum logic {SLOT_EMPTY, SLOT_FULL} res_slot_t.
- Add to the package: localparam INSTR_W = $bits(instruction_t).
- Sub-module: sync_fifo (parameters DEPTH and WIDTH; ports push, pop, wdata, rdata, count, full, empty), instantiated once. The result-slot FSM stays in alu_issue_queue.

Test Plan:
- Reset, then push {ADD,UNSIGNED,24'h5,24'h3} with res_ready=1 and the real `alu` attached -> res_valid=1 two cycles after acceptance, res_data=8, res_opc=ADD.
- Push SUB 5,3 then {MULT,UNSIGNED,24'd12,24'd3} back-to-back, res_ready=1 -> results 2 then 36 on consecutive cycles, in order.
- res_ready=0 and push 6 instructions -> in_ready drops after 5 accepts, count=4, res_data holds the first result. Then raise res_ready -> 5 results drain in order, and count reaches 0.
- Full queue with push and res_ready both asserted in the same cycle -> in_ready stays 0 for that cycle, count 4->3, no loss or duplication.
- Assert rst for one cycle while count=3 and res_valid=1 -> next cycle count=0, res_valid=0, instr=0, and no stale result ever appears.
- With ALU_ISSUE_STATS_EN: 3 issues plus 4 cycles of res_ready=0 while valid -> issued_cnt=3, stall_cnt=4.
